// File: rtl/lcd_host_seq.sv
// Host-side sequencer for the LCD image controller: runs a command script, streams
// the 12x9 image for load commands and checks each 16-pixel output burst.
module lcd_host_seq #(
    parameter int         CMD_AW   = 5,
    parameter int         TIMEOUT  = 1023,
    parameter logic [3:0] END_CODE = 4'hF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_start,
    output logic [CMD_AW-1:0] o_cmd_addr,
    input  logic [3:0]        i_cmd_rdata,
    output logic [6:0]        o_img_addr,
    input  logic [7:0]        i_img_rdata,
    output logic [3:0]        o_lcd_cmd,
    output logic              o_lcd_cmd_valid,
    output logic [7:0]        o_lcd_datain,
    input  logic              i_lcd_busy,
    input  logic              i_lcd_output_valid,
    output logic              o_running,
    output logic              o_done,
    output logic              o_err,
    output logic [CMD_AW:0]   o_cmd_count
);

    localparam int              TW        = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]   TMO_LAST  = TW'(TIMEOUT - 1);
    localparam logic [6:0]      LAST_PIX  = 7'd107;
    localparam logic [4:0]      OUT_EXP   = 5'd16;
    localparam logic [4:0]      OUT_MAX   = 5'd31;
    localparam logic [CMD_AW-1:0] LAST_ADDR = {CMD_AW{1'b1}};
    localparam logic [CMD_AW:0] CNT_MAX   = {1'b1, {CMD_AW{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_ISSUE  = 3'd3,
        S_LOAD   = 3'd4,
        S_WAIT   = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [CMD_AW-1:0] r_cmd_addr;
    logic [6:0]        r_img_addr;
    logic [6:0]        r_pix;
    logic [3:0]        r_lcd_cmd;
    logic              r_lcd_valid;
    logic [7:0]        r_datain;
    logic              r_running;
    logic              r_done;
    logic              r_err;
    logic [CMD_AW:0]   r_cmd_count;
    logic [4:0]        r_out_cnt;
    logic [TW-1:0]     r_tmo;
    logic              r_wait_first;

    logic w_is_end, w_illegal, w_last;
    logic w_start_acc, w_wait_done, w_timeout, w_advance, w_set_err;

    assign w_is_end  = (i_cmd_rdata == END_CODE);
    assign w_illegal = !w_is_end && (i_cmd_rdata >= 4'd9) && (i_cmd_rdata <= 4'd14);
    assign w_last    = (r_cmd_addr == LAST_ADDR);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   w_next = i_start ? S_FETCH : S_IDLE;
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: begin
                if (w_is_end) begin
                    w_next = S_DONE;
                end else if (w_illegal) begin
                    w_next = w_last ? S_DONE : S_FETCH;
                end else if (!i_lcd_busy) begin
                    w_next = S_ISSUE;
                end else begin
                    w_next = S_DECODE;
                end
            end
            S_ISSUE:  w_next = (r_lcd_cmd == 4'd0) ? S_LOAD : S_WAIT;
            S_LOAD:   w_next = (r_pix == LAST_PIX) ? S_WAIT : S_LOAD;
            S_WAIT: begin
                if (w_wait_done) begin
                    w_next = w_last ? S_DONE : S_FETCH;
                end else if (w_timeout) begin
                    w_next = S_DONE;
                end else begin
                    w_next = S_WAIT;
                end
            end
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Per-state strobes; the burst check ignores busy on the first WAIT cycle.
    always_comb begin
        w_start_acc = 1'b0;
        w_wait_done = 1'b0;
        w_timeout   = 1'b0;
        w_advance   = 1'b0;
        w_set_err   = 1'b0;
        case (r_state)
            S_IDLE:   w_start_acc = i_start;
            S_DECODE: begin
                if (w_illegal) begin
                    w_advance = 1'b1;
                    w_set_err = 1'b1;
                end else begin
                    w_advance = 1'b0;
                end
            end
            S_WAIT: begin
                if (!r_wait_first && !i_lcd_busy) begin
                    w_wait_done = 1'b1;
                    w_advance   = 1'b1;
                    w_set_err   = (r_out_cnt != OUT_EXP);
                end else if (r_tmo == TMO_LAST) begin
                    w_timeout = 1'b1;
                    w_set_err = 1'b1;
                end else begin
                    w_timeout = 1'b0;
                end
            end
            default:  w_start_acc = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cmd_addr   <= '0;
            r_img_addr   <= 7'd0;
            r_pix        <= 7'd0;
            r_lcd_cmd    <= 4'd0;
            r_lcd_valid  <= 1'b0;
            r_datain     <= 8'd0;
            r_running    <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_cmd_count  <= '0;
            r_out_cnt    <= 5'd0;
            r_tmo        <= '0;
            r_wait_first <= 1'b0;
        end else begin
            r_lcd_valid  <= (w_next == S_ISSUE);
            r_done       <= (w_next == S_DONE);
            r_wait_first <= (w_next == S_WAIT) && (r_state != S_WAIT);
            if (w_start_acc) begin
                r_err       <= 1'b0;
                r_cmd_count <= '0;
                r_cmd_addr  <= '0;
                r_running   <= 1'b1;
            end else begin
                if (w_set_err) r_err <= 1'b1;
                if (w_advance && !w_last) r_cmd_addr <= r_cmd_addr + 1'b1;
                if (w_next == S_DONE) r_running <= 1'b0;
            end
            if ((r_state == S_DECODE) && (w_next == S_ISSUE)) begin
                r_lcd_cmd  <= i_cmd_rdata;
                r_img_addr <= 7'd0;
            end
            // Image address leads the pixel on lcd_datain by one cycle of memory latency.
            case (r_state)
                S_ISSUE: begin
                    if (r_cmd_count != CNT_MAX) r_cmd_count <= r_cmd_count + 1'b1;
                    if (r_lcd_cmd == 4'd0) r_img_addr <= 7'd1;
                    r_out_cnt <= {4'd0, i_lcd_output_valid};
                    r_tmo     <= TW'(1);
                    r_pix     <= 7'd0;
                end
                S_LOAD: begin
                    if (r_img_addr != LAST_PIX) r_img_addr <= r_img_addr + 7'd1;
                    r_pix    <= r_pix + 7'd1;
                    r_datain <= i_img_rdata;
                    r_tmo    <= r_tmo + TW'(1);
                    if (i_lcd_output_valid && (r_out_cnt != OUT_MAX)) r_out_cnt <= r_out_cnt + 5'd1;
                end
                S_WAIT: begin
                    r_tmo <= r_tmo + TW'(1);
                    if (i_lcd_output_valid && (r_out_cnt != OUT_MAX)) r_out_cnt <= r_out_cnt + 5'd1;
                end
                default: r_tmo <= r_tmo;
            endcase
        end
    end

    assign o_cmd_addr      = r_cmd_addr;
    assign o_img_addr      = r_img_addr;
    assign o_lcd_cmd       = r_lcd_cmd;
    assign o_lcd_cmd_valid = r_lcd_valid;
    assign o_lcd_datain    = (r_state == S_LOAD) ? i_img_rdata : r_datain;
    assign o_running       = r_running;
    assign o_done          = r_done;
    assign o_err           = r_err;
    assign o_cmd_count     = r_cmd_count;

endmodule
